// File: rtl/data_mem_lw_ctrl.sv
// Load controller: issues a word-aligned memory read, then extracts and extends
// the addressed byte/halfword/word into Load_Data.
module data_mem_lw_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load_Start,
    input  logic [2:0]  Lw_Sw_OP,
    input  logic [31:0] Addr,
    output logic        Mem_Req_Valid,
    input  logic        Mem_Req_Ready,
    output logic [31:0] Mem_Req_Addr,
    input  logic        Mem_Resp_Valid,
    input  logic [31:0] Mem_Resp_Data,
    output logic        Load_Busy,
    output logic        Load_Done,
    output logic        Load_Error,
    output logic [31:0] Load_Data
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q, op_nxt;
    logic [31:0]       addr_q, addr_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              req_valid_nxt;
    logic [31:0]       req_addr_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic [31:0]       data_nxt;

    // Illegal opcode or an access that does not fit its natural alignment
    function automatic logic bad_request(input logic [2:0] op, input logic [1:0] lane);
        logic bad;
        case (op)
            OP_LB, OP_LBU: bad = 1'b0;
            OP_LH, OP_LHU: bad = lane[0];
            OP_LW:         bad = (lane != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lane,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'h0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= S_IDLE;
            op_q          <= 3'b000;
            addr_q        <= 32'h0;
            cnt_q         <= '0;
            Mem_Req_Valid <= 1'b0;
            Mem_Req_Addr  <= 32'h0;
            Load_Busy     <= 1'b0;
            Load_Done     <= 1'b0;
            Load_Error    <= 1'b0;
            Load_Data     <= 32'h0;
        end else begin
            state         <= state_nxt;
            op_q          <= op_nxt;
            addr_q        <= addr_nxt;
            cnt_q         <= cnt_nxt;
            Mem_Req_Valid <= req_valid_nxt;
            Mem_Req_Addr  <= req_addr_nxt;
            Load_Busy     <= busy_nxt;
            Load_Done     <= done_nxt;
            Load_Error    <= err_nxt;
            Load_Data     <= data_nxt;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        addr_nxt      = addr_q;
        cnt_nxt       = cnt_q;
        req_valid_nxt = 1'b0;
        req_addr_nxt  = Mem_Req_Addr;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        data_nxt      = Load_Data;

        case (state)
            S_IDLE: begin
                if (Load_Start) begin
                    op_nxt   = Lw_Sw_OP;
                    addr_nxt = Addr;
                    if (bad_request(Lw_Sw_OP, Addr[1:0])) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt     = S_REQ;
                        req_valid_nxt = 1'b1;
                        req_addr_nxt  = {Addr[31:2], 2'b00};
                    end
                end
            end
            S_REQ: begin
                if (Mem_Req_Ready) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    req_valid_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                // A response in the final cycle takes priority over the timeout
                if (Mem_Resp_Valid) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    data_nxt  = extract(op_q, addr_q[1:0], Mem_Resp_Data);
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = S_ERR;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_data_mem_lw_ctrl.sv
// Directed bench for data_mem_lw_ctrl: scoreboard of expected Load_Done/Load_Error
// results plus cycle-accurate handshake, latency, timeout and reset checks.
module tb_data_mem_lw_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Load_Start = 1'b0;
    logic [2:0]  Lw_Sw_OP = 3'b000;
    logic [31:0] Addr = 32'h0;
    logic        Mem_Req_Valid;
    logic        Mem_Req_Ready = 1'b0;
    logic [31:0] Mem_Req_Addr;
    logic        Mem_Resp_Valid = 1'b0;
    logic [31:0] Mem_Resp_Data = 32'h0;
    logic        Load_Busy;
    logic        Load_Done;
    logic        Load_Error;
    logic [31:0] Load_Data;

    localparam logic [31:0] W1 = 32'h808182F3;
    localparam logic [31:0] W2 = 32'h7F7E1234;

    data_mem_lw_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Load_Start     (Load_Start),
        .Lw_Sw_OP       (Lw_Sw_OP),
        .Addr           (Addr),
        .Mem_Req_Valid  (Mem_Req_Valid),
        .Mem_Req_Ready  (Mem_Req_Ready),
        .Mem_Req_Addr   (Mem_Req_Addr),
        .Mem_Resp_Valid (Mem_Resp_Valid),
        .Mem_Resp_Data  (Mem_Resp_Data),
        .Load_Busy      (Load_Busy),
        .Load_Done      (Load_Done),
        .Load_Error     (Load_Error),
        .Load_Data      (Load_Data)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_data = 32'h0;
    int          passed = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Scoreboard: every Done/Error pulse must match the oldest outstanding expectation
    always @(negedge Clk) begin
        if (!Rst && (Load_Done || Load_Error)) begin
            if (sb.size() == 0) begin
                chk_b("unexpected_done", Load_Done, 1'b0);
                chk_b("unexpected_error", Load_Error, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk_b("sb_error", Load_Error, mon_e.is_err);
                chk_b("sb_done", Load_Done, !mon_e.is_err);
                if (mon_e.is_err) begin
                    chk("sb_err_keeps_data", Load_Data, last_data);
                end else begin
                    chk("sb_load_data", Load_Data, mon_e.data);
                    last_data = mon_e.data;
                end
            end
        end
    end

    task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] word,
                           input int rdy_wait, input logic exp_err, input logic [31:0] exp_data,
                           input bit poke);
        Load_Start = 1'b1;
        Lw_Sw_OP   = op;
        Addr       = a;
        sb.push_back(exp_t'{is_err: exp_err, data: exp_data});
        @(posedge Clk) #1;
        Load_Start = 1'b0;
        Lw_Sw_OP   = 3'b111;
        Addr       = 32'hDEAD_BEEF;
        if (exp_err) begin
            @(negedge Clk);
            chk_b("err_at_t1", Load_Error, 1'b1);
            chk_b("err_no_req", Mem_Req_Valid, 1'b0);
            chk_b("err_busy", Load_Busy, 1'b1);
            @(posedge Clk) #1;
            @(negedge Clk);
            chk_b("err_one_cycle", Load_Error, 1'b0);
            chk_b("err_idle_busy", Load_Busy, 1'b0);
            chk_b("err_still_no_req", Mem_Req_Valid, 1'b0);
        end else begin
            for (int i = 0; i < rdy_wait; i++) begin
                @(negedge Clk);
                chk_b("req_valid_hold", Mem_Req_Valid, 1'b1);
                chk("req_addr_hold", Mem_Req_Addr, {a[31:2], 2'b00});
                @(posedge Clk) #1;
            end
            Mem_Req_Ready = 1'b1;
            if (poke) begin
                // Start and a bogus response during the handshake must both be ignored
                Load_Start     = 1'b1;
                Mem_Resp_Valid = 1'b1;
                Mem_Resp_Data  = ~word;
            end
            @(negedge Clk);
            chk_b("req_valid", Mem_Req_Valid, 1'b1);
            chk("req_addr", Mem_Req_Addr, {a[31:2], 2'b00});
            @(posedge Clk) #1;
            Mem_Req_Ready  = 1'b0;
            Load_Start     = 1'b0;
            Mem_Resp_Valid = 1'b1;
            Mem_Resp_Data  = word;
            @(negedge Clk);
            chk_b("wait_valid_low", Mem_Req_Valid, 1'b0);
            @(posedge Clk) #1;
            Mem_Resp_Valid = 1'b0;
            Mem_Resp_Data  = 32'h0;
            @(negedge Clk);
            chk_b("done_latency", Load_Done, 1'b1);
            chk_b("done_busy", Load_Busy, 1'b1);
            @(posedge Clk) #1;
            @(negedge Clk);
            chk_b("done_one_cycle", Load_Done, 1'b0);
            chk_b("done_idle_busy", Load_Busy, 1'b0);
            chk("data_held", Load_Data, exp_data);
        end
    endtask

    // resp_at = 16: response in the final WAIT cycle; 0: no response (timeout)
    task automatic do_wait_test(input int resp_at);
        Load_Start = 1'b1;
        Lw_Sw_OP   = 3'b010;
        Addr       = 32'h100;
        sb.push_back(exp_t'{is_err: (resp_at == 0), data: W1});
        @(posedge Clk) #1;
        Load_Start    = 1'b0;
        Mem_Req_Ready = 1'b1;
        @(posedge Clk) #1;
        Mem_Req_Ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == resp_at) begin
                Mem_Resp_Valid = 1'b1;
                Mem_Resp_Data  = W1;
            end
            @(negedge Clk);
            chk_b("wait_no_error", Load_Error, 1'b0);
            chk_b("wait_no_done", Load_Done, 1'b0);
            @(posedge Clk) #1;
            Mem_Resp_Valid = 1'b0;
        end
        @(negedge Clk);
        chk_b("wait_end_error", Load_Error, resp_at == 0);
        chk_b("wait_end_done", Load_Done, resp_at != 0);
        @(posedge Clk) #1;
        @(negedge Clk);
        chk_b("wait_end_busy", Load_Busy, 1'b0);
        chk_b("wait_end_pulse", Load_Error | Load_Done, 1'b0);
    endtask

    initial begin
        #2 Rst = 1'b1;
        @(negedge Clk);
        chk_b("rst_valid", Mem_Req_Valid, 1'b0);
        chk("rst_addr", Mem_Req_Addr, 32'h0);
        chk_b("rst_busy", Load_Busy, 1'b0);
        chk_b("rst_done", Load_Done, 1'b0);
        chk_b("rst_error", Load_Error, 1'b0);
        chk("rst_data", Load_Data, 32'h0);
        @(posedge Clk) #1;
        Rst = 1'b0;
        @(posedge Clk) #1;

        do_load(3'b000, 32'h103, W1, 0, 1'b0, 32'hFFFFFF80, 1'b0);
        do_load(3'b100, 32'h100, W1, 0, 1'b0, 32'h000000F3, 1'b0);
        do_load(3'b000, 32'h101, W1, 0, 1'b0, 32'hFFFFFF82, 1'b0);
        do_load(3'b001, 32'h102, W1, 0, 1'b0, 32'hFFFF8081, 1'b0);
        do_load(3'b101, 32'h100, W1, 0, 1'b0, 32'h000082F3, 1'b0);
        do_load(3'b010, 32'h100, W1, 1, 1'b0, 32'h808182F3, 1'b1);

        do_load(3'b010, 32'h101, W1, 0, 1'b1, 32'h0, 1'b0);
        do_load(3'b101, 32'h103, W1, 0, 1'b1, 32'h0, 1'b0);
        do_load(3'b011, 32'h100, W1, 0, 1'b1, 32'h0, 1'b0);
        do_load(3'b110, 32'h100, W1, 0, 1'b1, 32'h0, 1'b0);
        do_load(3'b001, 32'h101, W1, 0, 1'b1, 32'h0, 1'b0);

        do_load(3'b010, 32'h100, W1, 5, 1'b0, 32'h808182F3, 1'b0);

        do_load(3'b001, 32'h200, W2, 0, 1'b0, 32'h00001234, 1'b0);
        do_load(3'b000, 32'h203, W2, 0, 1'b0, 32'h0000007F, 1'b0);
        do_load(3'b100, 32'h202, W2, 0, 1'b0, 32'h0000007E, 1'b0);
        do_load(3'b001, 32'h202, W2, 2, 1'b0, 32'h00007F7E, 1'b0);
        do_load(3'b000, 32'h200, W2, 0, 1'b0, 32'h00000034, 1'b0);
        do_load(3'b100, 32'h201, W2, 0, 1'b0, 32'h00000012, 1'b0);

        do_wait_test(0);
        do_wait_test(16);

        // Reset in WAIT: outputs clear asynchronously, a late response is ignored
        Load_Start = 1'b1;
        Lw_Sw_OP   = 3'b010;
        Addr       = 32'h100;
        @(posedge Clk) #1;
        Load_Start    = 1'b0;
        Mem_Req_Ready = 1'b1;
        @(posedge Clk) #1;
        Mem_Req_Ready = 1'b0;
        chk_b("pre_rst_busy", Load_Busy, 1'b1);
        #1 Rst = 1'b1;
        #1;
        chk_b("arst_busy", Load_Busy, 1'b0);
        chk_b("arst_valid", Mem_Req_Valid, 1'b0);
        chk("arst_addr", Mem_Req_Addr, 32'h0);
        chk("arst_data", Load_Data, 32'h0);
        chk_b("arst_done", Load_Done, 1'b0);
        chk_b("arst_error", Load_Error, 1'b0);
        sb.delete();
        last_data = 32'h0;
        @(posedge Clk) #1;
        Rst = 1'b0;
        @(posedge Clk) #1;
        @(posedge Clk) #1;
        Mem_Resp_Valid = 1'b1;
        Mem_Resp_Data  = W1;
        @(posedge Clk) #1;
        Mem_Resp_Valid = 1'b0;
        @(negedge Clk);
        chk_b("stale_resp_done", Load_Done, 1'b0);
        chk_b("stale_resp_busy", Load_Busy, 1'b0);
        @(posedge Clk) #1;
        do_load(3'b010, 32'h100, W1, 0, 1'b0, 32'h808182F3, 1'b0);

        repeat (3) @(posedge Clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, passed + fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_lw_ctrl.md
DATA_MEM_LW_CTRL -- requirements
Module: data_mem_lw_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: WAIT-state cycles without a response before a load is aborted; legal range 2-255.
REQ-002 SHALL have port Clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port Load_Start  in  1  one-cycle load request; sampled only in IDLE.
REQ-005 SHALL have port Lw_Sw_OP  in  3  load op, RISC-V funct3 encoding: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-006 SHALL have port Addr  in  32  byte address of the load.
REQ-007 SHALL have port Mem_Req_Valid  out  1  memory read request valid.
REQ-008 SHALL have port Mem_Req_Ready  in  1  memory accepts the request.
REQ-009 SHALL have port Mem_Req_Addr  out  32  word-aligned read address.
REQ-010 SHALL have port Mem_Resp_Valid  in  1  read data valid.
REQ-011 SHALL have port Mem_Resp_Data  in  32  raw 32-bit memory word.
REQ-012 SHALL have port Load_Busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port Load_Done  out  1  one-cycle pulse; Load_Data is valid in that cycle.
REQ-014 SHALL have port Load_Error  out  1  one-cycle pulse on a misaligned load, an illegal op, or a timeout.
REQ-015 SHALL have port Load_Data  out  32  aligned and extended load result; registered.

Function
REQ-016 SHALL implement a five-state FSM: IDLE, REQ, WAIT, DONE, ERR.
REQ-017 IDLE + Load_Start SHALL latch Lw_Sw_OP and Addr.
- Next state is ERR if the op is illegal, or LH/LHU with Addr[0]=1, or LW with Addr[1:0]!=00.
- Otherwise next state is REQ.
REQ-018 REQ SHALL drive Mem_Req_Valid=1 and Mem_Req_Addr={latched Addr[31:2],2'b00}.
- Both are held stable until Mem_Req_Ready=1, then next state is WAIT.
REQ-019 Mem_Req_Valid SHALL be 0 in every state other than REQ; Mem_Req_Addr SHALL hold its last value.
REQ-020 WAIT SHALL clear the timeout counter on entry and increment it each cycle without a response.
- Mem_Resp_Valid=1 captures the result and moves to DONE.
- Counter at TIMEOUT_CYCLES-1 with no response moves to ERR.
- A response in that same cycle wins over the timeout.
REQ-021 Mem_Resp_Valid SHALL be ignored in every state except WAIT, including the REQ handshake cycle.
REQ-022 Extraction SHALL use the latched byte lane Addr[1:0]:
- LB: sign-extend Mem_Resp_Data[8*lane+7:8*lane].
- LBU: zero-extend the same byte.
- LH: sign-extend the halfword at Addr[1] (0 = bits 15:0, 1 = bits 31:16).
- LHU: zero-extend the same halfword.
- LW: pass the word unchanged.
REQ-023 DONE SHALL assert Load_Done for exactly one cycle, then return to IDLE; Load_Data SHALL hold until the next DONE.
REQ-024 ERR SHALL assert Load_Error for exactly one cycle, leave Load_Data unchanged, and return to IDLE.
REQ-025 Load_Start while Load_Busy=1 SHALL be ignored, not queued.
REQ-026 Minimum latency SHALL be 3 cycles: Load_Start at edge T, Ready at T+1, Resp at T+2, Load_Done high at T+3.
REQ-027 Misalign/illegal detection SHALL reach ERR at T+1, so Load_Error is high at T+1 and no memory request is issued.

Reset
REQ-028 Rst=1 SHALL immediately force the following, from any state including mid-handshake:
- state=IDLE;
- Mem_Req_Valid=0, Mem_Req_Addr=0;
- Load_Busy=0, Load_Done=0, Load_Error=0;
- Load_Data=0, timeout counter=0.
REQ-029 After Rst deasserts, a stale Mem_Resp_Valid SHALL NOT produce Load_Done.

Verification
REQ-030 Memory word 0x808182F3 at 0x100:
- LB @0x103 -> Load_Data=0xFFFFFF80.
- LBU @0x100 -> 0x000000F3.
- LB @0x101 -> 0xFFFFFF82.
REQ-031 Same word:
- LH @0x102 -> 0xFFFF8081.
- LHU @0x100 -> 0x000082F3.
- LW @0x100 -> 0x808182F3.
- Each completes with Load_Done exactly 3 cycles after Load_Start under zero-wait memory.
REQ-032 Misaligned and illegal requests:
- LW @0x101 -> Load_Error pulse one cycle after start; Mem_Req_Valid never asserts.
- LHU @0x103 -> same response.
- op=011 -> same response.
REQ-033 Mem_Req_Ready held low 5 cycles -> Mem_Req_Valid=1 and Mem_Req_Addr=0x100 stable all 5 cycles; Load_Done 8 cycles after start.
REQ-034 TIMEOUT_CYCLES=16, no response -> Load_Error pulse 16 cycles after WAIT entry, then Load_Busy=0; response arriving on cycle 16 instead -> Load_Done, no Load_Error.
REQ-035 Rst pulsed in WAIT -> all outputs 0 asynchronously; a Mem_Resp_Valid two cycles later -> no Load_Done; a new LW then completes normally.
